// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, frame field widths and the default frame start marker.
package im_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;
  localparam int LANES  = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = byte source / memory side, slave = the loader itself.
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/im_loader_word_assembler.sv
// MSB-first 4-byte word assembler with a running XOR checksum over every
// shifted-in byte. word_full flags the byte that completes a word, and
// word_nxt exposes the word as it will look once that byte is shifted in.
module im_loader_word_assembler
  import im_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word_nxt,
  output logic [BYTE_W-1:0] csum,
  output logic              word_full
);

  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Next lane/word/checksum; clear wins so a new frame starts from zero.
  always_comb begin
    word_nxt  = {word_q[DATA_W-BYTE_W-1:0], byte_in};
    word_full = shift_en && (lane_q == 2'd3);
    lane_d    = lane_q;
    word_d    = word_q;
    csum_d    = csum_q;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
      csum_d = '0;
    end else if (shift_en) begin
      lane_d = lane_q + 2'd1;
      word_d = word_nxt;
      csum_d = csum_q ^ byte_in;
    end
  end

  // Lane counter, shift register and checksum state.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      lane_q <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader. Parses SYNC, CNT_HI, CNT_LO, N words
// (MSB first) and an XOR checksum, writes each word into im with a one-cycle
// strobe, and releases cpu_rst_f only after a frame with a good checksum.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int                MAX_WORDS  = 1024
) (
  input  logic        CLK,
  input  logic        RST_F,
  im_loader_if.slave  bus,
  output logic        cpu_rst_f,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
  logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic              cpu_rst_f_q, cpu_rst_f_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              xfer;
  logic              is_sync;
  logic [CNT_W-1:0]  cnt_full;
  logic [CNT_W-1:0]  index_inc;
  logic              asm_clear;
  logic              asm_shift;
  logic              word_full;
  logic [DATA_W-1:0] word_nxt;
  logic [BYTE_W-1:0] csum;

  assign xfer      = bus.byte_valid & byte_ready_q;
  assign is_sync   = (bus.byte_data == SYNC_BYTE);
  assign cnt_full  = {cnt_q[CNT_W-1:BYTE_W], bus.byte_data};
  assign index_inc = index_q + CNT_W'(1);

  im_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (CLK),
    .rst_f     (RST_F),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (bus.byte_data),
    .word_nxt  (word_nxt),
    .csum      (csum),
    .word_full (word_full)
  );

  // Frame parser next state; outputs are decoded from the next state so
  // they change on the same edge the FSM enters a state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    index_d    = index_q;
    im_waddr_d = im_waddr_q;
    im_wdata_d = im_wdata_q;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (xfer && is_sync) begin
          state_d   = ST_CNT_HI;
          index_d   = '0;
          asm_clear = 1'b1;
        end
      end
      ST_CNT_HI: begin
        if (xfer) begin
          cnt_d   = {bus.byte_data, cnt_q[BYTE_W-1:0]};
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          cnt_d = cnt_full;
          if (cnt_full > MAX_CNT)   state_d = ST_ERR;
          else if (cnt_full == '0)  state_d = ST_CSUM;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          if (word_full) begin
            state_d    = ST_WRITE;
            im_waddr_d = START_ADDR + ADDR_W'(index_q);
            im_wdata_d = word_nxt;
          end
        end
      end
      ST_WRITE: begin
        index_d = index_inc;
        state_d = (index_inc == cnt_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (xfer) state_d = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    byte_ready_d = !((state_d == ST_WRITE) || (state_d == ST_DONE));
    im_we_d      = (state_d == ST_WRITE);
    load_done_d  = (state_d == ST_DONE);
    cpu_rst_f_d  = (state_d == ST_DONE);
    load_err_d   = (state_d == ST_ERR);
  end

  // FSM state, frame bookkeeping and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_F) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      index_q      <= '0;
      byte_ready_q <= 1'b1;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      cpu_rst_f_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_rst_f_q  <= cpu_rst_f_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.im_we      = im_we_q;
  assign bus.im_waddr   = im_waddr_q;
  assign bus.im_wdata   = im_wdata_q;
  assign cpu_rst_f      = cpu_rst_f_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed frames plus randomized frames, checked every
// cycle against a frame-position parser model and pinned with literal values.
module tb_im_loader;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 32;
  localparam int          MAX_WORDS = 1024;
  localparam logic [15:0] START     = 16'h0000;

  logic CLK = 1'b0;
  logic RST_F = 1'b0;
  logic cpu_rst_f, load_done, load_err;

  im_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  im_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(START),
    .SYNC_BYTE(8'hA5), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .CLK       (CLK),
    .RST_F     (RST_F),
    .bus       (bus),
    .cpu_rst_f (cpu_rst_f),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame of each accepted byte.
  bit          m_live = 0;
  bit          m_ready = 1, m_we = 0, m_done = 0, m_err = 0, hunting = 1;
  logic [15:0] m_waddr = '0;
  logic [31:0] m_wdata = '0, m_word = '0;
  logic [7:0]  m_cs = '0;
  int          pos = 0, n = 0;

  initial begin
    forever begin
      @(posedge CLK);
      if (!RST_F) begin
        m_live = 1; m_ready = 1; m_we = 0; m_done = 0; m_err = 0; hunting = 1;
        m_waddr = '0; m_wdata = '0; m_word = '0; m_cs = '0; pos = 0; n = 0;
      end else begin
        logic [7:0] xb;
        bit xfer;
        xb   = bus.byte_data;
        xfer = bus.byte_valid && m_ready;
        m_we = 0;
        if (xfer) begin
          if (hunting) begin
            if (xb == 8'hA5) begin
              hunting = 0; m_err = 0; pos = 1; m_cs = '0; m_word = '0;
            end
          end else if (pos == 1) begin
            n = int'(xb) * 256; pos = 2;
          end else if (pos == 2) begin
            n = n + int'(xb);
            if (n > MAX_WORDS) begin m_err = 1; hunting = 1; end
            else pos = 3;
          end else if (pos < 3 + 4 * n) begin
            int k;
            k = pos - 3;
            m_word = {m_word[23:0], xb};
            m_cs   = m_cs ^ xb;
            if (k % 4 == 3) begin
              m_we = 1; m_waddr = START + 16'(k / 4); m_wdata = m_word;
            end
            pos++;
          end else begin
            if (xb == m_cs) m_done = 1;
            else begin m_err = 1; hunting = 1; end
          end
        end
        m_ready = !(m_we || m_done);
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of DUT writes.
  logic [15:0] dut_wa[$];
  logic [31:0] dut_wd[$];

  initial begin
    forever begin
      @(negedge CLK);
      if (m_live) begin
        chk("im_we", bus.im_we, m_we);
        chk("byte_ready", bus.byte_ready, m_ready);
        chk("load_done", load_done, m_done);
        chk("load_err", load_err, m_err);
        chk("cpu_rst_f", cpu_rst_f, m_done);
        if (m_we) begin
          chk("im_waddr", bus.im_waddr, m_waddr);
          chk("im_wdata", bus.im_wdata, m_wdata);
        end
        if (bus.im_we === 1'b1) begin
          dut_wa.push_back(bus.im_waddr);
          dut_wd.push_back(bus.im_wdata);
        end
      end
    end
  end

  logic [7:0] tx[$];

  task automatic clear_log();
    dut_wa.delete();
    dut_wd.delete();
  endtask

  task automatic do_reset();
    RST_F = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge CLK);
    chk("rst_waddr", bus.im_waddr, 16'h0000);
    chk("rst_wdata", bus.im_wdata, 32'h0);
    chk("rst_ready", bus.byte_ready, 1'b1);
    chk("rst_cpu_rst_f", cpu_rst_f, 1'b0);
    RST_F = 1'b1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 0;
    repeat (gap) @(negedge CLK);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 40 && !got; t++) begin
      got = bus.byte_ready;
      @(negedge CLK);
    end
    bus.byte_valid = 1'b0;
    chk("byte_accepted", got, 1'b1);
  endtask

  task automatic send_tx(input int gapmax);
    foreach (tx[i]) send_byte(tx[i], int'($urandom_range(0, gapmax)));
    repeat (3) @(negedge CLK);
  endtask

  task automatic build_frame(input int nw, input bit rnd, input bit bad);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    tx.delete();
    tx.push_back(8'hA5);
    tx.push_back(8'(nw >> 8));
    tx.push_back(8'(nw));
    for (int i = 0; i < nw; i++) begin
      w = rnd ? $urandom : (32'(i) * 32'h01010101) ^ 32'hDEADBEEF;
      for (int j = 3; j >= 0; j--) begin
        tx.push_back(w[j*8 +: 8]);
        cs = cs ^ w[j*8 +: 8];
      end
    end
    tx.push_back(bad ? ~cs : cs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge CLK);
    do_reset();

    // Single-word frame.
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_tx(2);
    chk("t1_writes", dut_wa.size(), 1);
    if (dut_wa.size() > 0) begin
      chk("t1_addr", dut_wa[0], 16'h0000);
      chk("t1_data", dut_wd[0], 32'h12345678);
    end
    chk("t1_done", load_done, 1'b1);
    chk("t1_cpu_rst_f", cpu_rst_f, 1'b1);

    // Two words, back to back.
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    send_tx(0);
    chk("t2_writes", dut_wa.size(), 2);
    if (dut_wa.size() > 1) begin
      chk("t2_addr1", dut_wa[1], 16'h0001);
      chk("t2_data1", dut_wd[1], 32'h00000002);
    end
    chk("t2_done", load_done, 1'b1);

    // Bad checksum, then recovery by a good frame.
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
    send_tx(1);
    chk("t3_err", load_err, 1'b1);
    chk("t3_cpu_rst_f", cpu_rst_f, 1'b0);
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_tx(1);
    chk("t3_err_clr", load_err, 1'b0);
    chk("t3_done", load_done, 1'b1);
    chk("t3_writes", dut_wa.size(), 2);

    // Leading garbage, empty frame.
    do_reset();
    tx = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_tx(1);
    chk("t4_writes", dut_wa.size(), 0);
    chk("t4_done", load_done, 1'b1);

    // Count above the limit.
    do_reset();
    tx = '{8'hA5, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_tx(1);
    chk("t5_err", load_err, 1'b1);
    chk("t5_writes", dut_wa.size(), 0);
    chk("t5_done", load_done, 1'b0);

    // Reset mid-word, then a clean reload.
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    send_tx(0);
    do_reset();
    chk("t6_writes", dut_wa.size(), 0);
    chk("t6_cpu_rst_f", cpu_rst_f, 1'b0);
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_tx(1);
    chk("t6_done", load_done, 1'b1);
    chk("t6_writes_after", dut_wa.size(), 1);

    // Largest legal count.
    do_reset();
    build_frame(MAX_WORDS, 1'b0, 1'b0);
    send_tx(0);
    chk("tmax_writes", dut_wa.size(), MAX_WORDS);
    if (dut_wa.size() > 0) chk("tmax_last_addr", dut_wa[dut_wa.size()-1], 16'h03FF);
    chk("tmax_done", load_done, 1'b1);

    // Randomized frames, some with leading garbage and bad checksums.
    for (int f = 0; f < 12; f++) begin
      int nw;
      bit bad;
      do_reset();
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hA4)), 0);
      nw  = int'($urandom_range(0, 8));
      bad = ($urandom_range(0, 3) == 0);
      build_frame(nw, 1'b1, bad);
      send_tx(2);
      chk("rnd_done", load_done, !bad);
      chk("rnd_err", load_err, bad);
      if (bad) begin
        build_frame(nw, 1'b1, 1'b0);
        send_tx(2);
        chk("rnd_recover", load_done, 1'b1);
      end
    end

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
